// File: rtl/pe_stream_server_pkg.sv
// Shared types and default widths for the PE stream-request responder and its bench.
package pe_stream_server_pkg;
  localparam int DFLT_DATA_W  = 16;
  localparam int DFLT_ADDR_W  = 12;
  localparam int DFLT_LEN_W   = 10;
  localparam int DFLT_K_W     = 6;
  localparam int DFLT_LAYER_W = 2;

  typedef struct packed {
    logic                    Req_Stream_filter_valid;
    logic [DFLT_K_W-1:0]     Req_Stream_filter_k;
    logic [DFLT_LAYER_W-1:0] Req_Stream_Conv_Layer_num;
    logic                    Req_Stream_input_valid;
  } Req_Stream;

  typedef enum logic [1:0] {
    IDLE,
    FILTER,
    INPUT,
    HOLD
  } server_state_e;
endpackage

// File: rtl/pe_stream_server_if.sv
// Ready/valid beat stream from the stream server (master) to the PE datapath (slave).
interface pe_stream_server_if
  import pe_stream_server_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W
);
  logic              strm_valid;
  logic              strm_ready;
  logic [DATA_W-1:0] strm_data;
  logic              strm_is_filter;
  logic              strm_last;

  modport master (
    output strm_valid,
    output strm_data,
    output strm_is_filter,
    output strm_last,
    input  strm_ready
  );

  modport slave (
    input  strm_valid,
    input  strm_data,
    input  strm_is_filter,
    input  strm_last,
    output strm_ready
  );
endinterface

// File: rtl/pe_stream_server_skid_fifo.sv
// Two-entry FIFO absorbing SRAM read returns ahead of the outgoing beat stream.
module stream_skid_fifo #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Flush outranks a same-cycle write so a read returning during an abort is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      if (rst) begin
        mem[0] <= '0;
        mem[1] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/pe_stream_server.sv
// Responder for PE stream requests: fetches a kernel's filter chunk and optionally the
// input activations from SRAM, streams them as beats, then holds the finish handshakes.
module pe_stream_server
  import pe_stream_server_pkg::*;
#(
  parameter int DATA_W  = DFLT_DATA_W,
  parameter int ADDR_W  = DFLT_ADDR_W,
  parameter int LEN_W   = DFLT_LEN_W,
  parameter int K_W     = DFLT_K_W,
  parameter int LAYER_W = DFLT_LAYER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  Req_Stream          Req_Stream_PE,
  output logic [LAYER_W-1:0] cfg_layer_sel,
  input  logic [ADDR_W-1:0]  cfg_filter_base,
  input  logic [LEN_W-1:0]   cfg_filter_len,
  input  logic [ADDR_W-1:0]  cfg_input_base,
  input  logic [LEN_W-1:0]   cfg_input_len,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  pe_stream_server_if.master strm,
  output logic               Stream_filter_finish,
  output logic               Stream_input_finish_PE
);
  localparam int ENTRY_W = DATA_W + 2;

  server_state_e      state, state_nxt;
  logic [ADDR_W-1:0]  base_f, base_i, cur_base, chunk_off;
  logic [LEN_W-1:0]   len_f, len_i, cur_len;
  logic [LEN_W-1:0]   rd_cnt, out_cnt, out_cnt_nxt;
  logic               want_i;
  logic               inflight, tag_is_filter, tag_last;
  logic               fin_f, fin_i, set_fin_f, set_fin_i;
  logic               accept, abort, phase_done, rd_en, pop, req_any;
  logic [2:0]         credit;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] head;
  logic               head_valid;

  assign req_any       = Req_Stream_PE.Req_Stream_filter_valid | Req_Stream_PE.Req_Stream_input_valid;
  assign cfg_layer_sel = Req_Stream_PE.Req_Stream_Conv_Layer_num;
  assign chunk_off     = ADDR_W'({{LEN_W{1'b0}}, Req_Stream_PE.Req_Stream_filter_k} *
                                 {{K_W{1'b0}}, cfg_filter_len});
  assign cur_base      = (state == FILTER) ? base_f : base_i;
  assign cur_len       = (state == FILTER) ? len_f : len_i;
  assign head_valid    = (fifo_count != 2'd0);
  assign pop           = head_valid & strm.strm_ready;
  assign out_cnt_nxt   = out_cnt + {{(LEN_W-1){1'b0}}, pop};
  // Reads in flight plus buffered beats never exceed the two FIFO slots.
  assign credit        = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    abort      = 1'b0;
    phase_done = 1'b0;
    rd_en      = 1'b0;
    set_fin_f  = 1'b0;
    set_fin_i  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_any && !fin_f && !fin_i) begin
          accept    = 1'b1;
          state_nxt = Req_Stream_PE.Req_Stream_filter_valid ? FILTER : INPUT;
        end
      end
      FILTER, INPUT: begin
        if (!req_any) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          rd_en = (rd_cnt != cur_len) && (credit < 3'd2);
          if (out_cnt_nxt == cur_len) begin
            phase_done = 1'b1;
            if (state == FILTER) begin
              set_fin_f = 1'b1;
              state_nxt = want_i ? INPUT : HOLD;
            end else begin
              set_fin_i = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!fin_f && !fin_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      base_f        <= '0;
      base_i        <= '0;
      len_f         <= '0;
      len_i         <= '0;
      want_i        <= 1'b0;
      rd_cnt        <= '0;
      out_cnt       <= '0;
      inflight      <= 1'b0;
      tag_is_filter <= 1'b0;
      tag_last      <= 1'b0;
      fin_f         <= 1'b0;
      fin_i         <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      fin_f    <= set_fin_f | (fin_f & Req_Stream_PE.Req_Stream_filter_valid);
      fin_i    <= set_fin_i | (fin_i & Req_Stream_PE.Req_Stream_input_valid);
      if (rd_en) begin
        tag_is_filter <= (state == FILTER);
        tag_last      <= (rd_cnt == cur_len - LEN_W'(1));
      end
      if (accept) begin
        base_f  <= cfg_filter_base + chunk_off;
        len_f   <= cfg_filter_len;
        base_i  <= cfg_input_base;
        len_i   <= cfg_input_len;
        want_i  <= Req_Stream_PE.Req_Stream_input_valid;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else if (phase_done || abort) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_en) begin
          rd_cnt <= rd_cnt + LEN_W'(1);
        end
        out_cnt <= out_cnt_nxt;
      end
    end
  end

  stream_skid_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .wr_en   (inflight),
    .wr_data ({mem_rd_data, tag_is_filter, tag_last}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign mem_rd_en              = rd_en;
  assign mem_rd_addr            = rd_en ? (cur_base + {{(ADDR_W-LEN_W){1'b0}}, rd_cnt}) : '0;
  assign strm.strm_valid        = head_valid;
  assign strm.strm_data         = head_valid ? head[ENTRY_W-1:2] : '0;
  assign strm.strm_is_filter    = head_valid & head[1];
  assign strm.strm_last         = head_valid & head[0];
  assign Stream_filter_finish   = fin_f;
  assign Stream_input_finish_PE = fin_i;
endmodule

// File: tb/tb_pe_stream_server.sv
// Directed bench for pe_stream_server; the SRAM model returns {4'hC, addr} one cycle after each read.
module tb_pe_stream_server;
  import pe_stream_server_pkg::*;

  logic        clk;
  logic        rst;
  Req_Stream   req;
  logic [1:0]  cfg_layer_sel;
  logic [11:0] cfg_filter_base;
  logic [9:0]  cfg_filter_len;
  logic [11:0] cfg_input_base;
  logic [9:0]  cfg_input_len;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        Stream_filter_finish;
  logic        Stream_input_finish_PE;

  int checks   = 0;
  int failures = 0;

  pe_stream_server_if #(.DATA_W(16)) s_if ();

  pe_stream_server dut (
    .clk                    (clk),
    .rst                    (rst),
    .Req_Stream_PE          (req),
    .cfg_layer_sel          (cfg_layer_sel),
    .cfg_filter_base        (cfg_filter_base),
    .cfg_filter_len         (cfg_filter_len),
    .cfg_input_base         (cfg_input_base),
    .cfg_input_len          (cfg_input_len),
    .mem_rd_en              (mem_rd_en),
    .mem_rd_addr            (mem_rd_addr),
    .mem_rd_data            (mem_rd_data),
    .strm                   (s_if),
    .Stream_filter_finish   (Stream_filter_finish),
    .Stream_input_finish_PE (Stream_input_finish_PE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? {4'hC, mem_rd_addr} : 16'hDEAD;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [5:0] k, input logic [1:0] layer,
                               input logic iv);
    req.Req_Stream_filter_valid   = fv;
    req.Req_Stream_filter_k       = k;
    req.Req_Stream_Conv_Layer_num = layer;
    req.Req_Stream_input_valid    = iv;
  endtask

  task automatic checkOutput(input string tag, input logic e_rd, input logic [11:0] e_addr,
                             input logic e_valid, input logic [15:0] e_data, input logic e_isf,
                             input logic e_last, input logic e_ff, input logic e_fi);
    #1;
    chk({tag, ".rd_en"}, 32'(mem_rd_en), 32'(e_rd));
    chk({tag, ".rd_addr"}, 32'(mem_rd_addr), 32'(e_addr));
    chk({tag, ".valid"}, 32'(s_if.strm_valid), 32'(e_valid));
    chk({tag, ".data"}, 32'(s_if.strm_data), 32'(e_data));
    chk({tag, ".is_filter"}, 32'(s_if.strm_is_filter), 32'(e_isf));
    chk({tag, ".last"}, 32'(s_if.strm_last), 32'(e_last));
    chk({tag, ".fin_f"}, 32'(Stream_filter_finish), 32'(e_ff));
    chk({tag, ".fin_i"}, 32'(Stream_input_finish_PE), 32'(e_fi));
  endtask

  initial begin
    int beats;
    int reads;
    logic stalled;
    logic [15:0] stall_data;
    logic stall_last;
    logic [15:0] exp_beat;

    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    s_if.strm_ready = 1'b1;
    cfg_filter_base = 12'h100;
    cfg_filter_len  = 10'd4;
    cfg_input_base  = 12'h200;
    cfg_input_len   = 10'd2;
    tick();
    tick();
    checkOutput("reset", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    checkOutput("idle", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);

    // Filter k=3 (base 0x10C, 4 beats) followed by 2 input beats, ready held high.
    tick();
    applyStimulus(1'b1, 6'd3, 2'd0, 1'b1);
    checkOutput("t1.accept", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t1.c1", 1, 12'h10C, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t1.c2", 1, 12'h10D, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t1.c3", 1, 12'h10E, 1, 16'hC10C, 1, 0, 0, 0);
    tick(); checkOutput("t1.c4", 1, 12'h10F, 1, 16'hC10D, 1, 0, 0, 0);
    tick(); checkOutput("t1.c5", 0, 12'h0, 1, 16'hC10E, 1, 0, 0, 0);
    tick(); checkOutput("t1.c6", 0, 12'h0, 1, 16'hC10F, 1, 1, 0, 0);
    tick(); checkOutput("t1.c7", 1, 12'h200, 0, 16'h0, 0, 0, 1, 0);
    tick(); checkOutput("t1.c8", 1, 12'h201, 0, 16'h0, 0, 0, 1, 0);
    tick(); checkOutput("t1.c9", 0, 12'h0, 1, 16'hC200, 0, 0, 1, 0);
    tick(); checkOutput("t1.c10", 0, 12'h0, 1, 16'hC201, 0, 1, 1, 0);
    tick(); checkOutput("t1.c11", 0, 12'h0, 0, 16'h0, 0, 0, 1, 1);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    checkOutput("t1.drop", 0, 12'h0, 0, 16'h0, 0, 0, 1, 1);
    tick(); checkOutput("t1.clear", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick();

    // Filter-only k=1 (base 0x103, 3 beats) with ready toggling every cycle.
    cfg_filter_len = 10'd3;
    tick();
    applyStimulus(1'b1, 6'd1, 2'd2, 1'b0);
    #1;
    chk("t2.layer_sel", 32'(cfg_layer_sel), 32'd2);
    tick();
    beats = 0;
    reads = 0;
    stalled = 1'b0;
    stall_data = 16'h0;
    stall_last = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s_if.strm_ready = (cyc % 2 == 0);
      #1;
      if (Stream_filter_finish) break;
      if (mem_rd_en) reads++;
      if (stalled) begin
        chk("t2.stall_valid", 32'(s_if.strm_valid), 32'd1);
        chk("t2.stall_data", 32'(s_if.strm_data), 32'(stall_data));
        chk("t2.stall_last", 32'(s_if.strm_last), 32'(stall_last));
      end
      stalled    = s_if.strm_valid & ~s_if.strm_ready;
      stall_data = s_if.strm_data;
      stall_last = s_if.strm_last;
      if (s_if.strm_valid && s_if.strm_ready) begin
        exp_beat = 16'hC103 + 16'(beats);
        chk("t2.beat_data", 32'(s_if.strm_data), 32'(exp_beat));
        chk("t2.beat_is_filter", 32'(s_if.strm_is_filter), 32'd1);
        chk("t2.beat_last", 32'(s_if.strm_last), 32'(beats == 2));
        beats++;
      end
      chk("t2.outstanding_le2", 32'((reads - beats) <= 2), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("t2.finish", 32'(Stream_filter_finish), 32'd1);
    chk("t2.beat_count", 32'(beats), 32'd3);
    chk("t2.read_count", 32'(reads), 32'd3);
    chk("t2.valid_after", 32'(s_if.strm_valid), 32'd0);
    s_if.strm_ready = 1'b1;
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    tick();
    tick();
    tick();

    // Zero-length filter chunk, then a new 1-beat request right after the flag clears.
    cfg_filter_len = 10'd0;
    applyStimulus(1'b1, 6'd5, 2'd0, 1'b0);
    checkOutput("t3.accept", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t3.c1", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t3.c2", 0, 12'h0, 0, 16'h0, 0, 0, 1, 0);
    tick(); checkOutput("t3.c3", 0, 12'h0, 0, 16'h0, 0, 0, 1, 0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    checkOutput("t3.drop", 0, 12'h0, 0, 16'h0, 0, 0, 1, 0);
    tick();
    cfg_filter_len = 10'd1;
    applyStimulus(1'b1, 6'd0, 2'd0, 1'b0);
    checkOutput("t3.clear", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t3.idle", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t3.rd", 1, 12'h100, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t3.wait", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t3.beat", 0, 12'h0, 1, 16'hC100, 1, 1, 0, 0);
    tick(); checkOutput("t3.fin", 0, 12'h0, 0, 16'h0, 0, 0, 1, 0);
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    tick();
    tick();
    tick();

    // Abort a 5-beat chunk (base 0x10A) after two beats, then a fresh 2-beat request.
    cfg_filter_len = 10'd5;
    cfg_input_len  = 10'd2;
    applyStimulus(1'b1, 6'd2, 2'd0, 1'b1);
    tick(); checkOutput("t4.c1", 1, 12'h10A, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t4.c2", 1, 12'h10B, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t4.c3", 1, 12'h10C, 1, 16'hC10A, 1, 0, 0, 0);
    tick(); checkOutput("t4.c4", 1, 12'h10D, 1, 16'hC10B, 1, 0, 0, 0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    s_if.strm_ready = 1'b0;
    checkOutput("t4.abort", 0, 12'h0, 1, 16'hC10C, 1, 0, 0, 0);
    tick();
    s_if.strm_ready = 1'b1;
    checkOutput("t4.flushed", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick();
    cfg_filter_len = 10'd2;
    applyStimulus(1'b1, 6'd0, 2'd0, 1'b0);
    checkOutput("t4.idle", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t4.n1", 1, 12'h100, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t4.n2", 1, 12'h101, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t4.n3", 0, 12'h0, 1, 16'hC100, 1, 0, 0, 0);
    tick(); checkOutput("t4.n4", 0, 12'h0, 1, 16'hC101, 1, 1, 0, 0);
    tick(); checkOutput("t4.n5", 0, 12'h0, 0, 16'h0, 0, 0, 1, 0);
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    tick();
    tick();
    tick();

    // Input-only request interrupted by reset while a read is outstanding.
    cfg_input_len = 10'd4;
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b1);
    tick(); checkOutput("t5.c1", 1, 12'h200, 0, 16'h0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    checkOutput("t5.c2", 1, 12'h201, 0, 16'h0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 6'd0, 2'd0, 1'b0);
    checkOutput("t5.reset", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t5.late1", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);
    tick(); checkOutput("t5.late2", 0, 12'h0, 0, 16'h0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
